embedding_packer: RTL

- Streaming producer for the sign-magnitude dot-product datapath.
- Accepts one signed embedding element per handshake and quantizes it to a 4-bit magnitude plus a sign bit.
- Packs N elements into a magnitude word and a sign vector, lane i at bits [MAG_W*i +: MAG_W] and sign[i], which is the exact layout the dot-product block consumes.
- Double-buffered: collection of the next vector continues while the previous packed vector waits for the consumer.

---
 rtl/embedding_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/embedding_packer.sv
// Streaming producer for the sign-magnitude dot-product datapath.
// Quantizes signed elements to a sign bit plus a saturated magnitude,
// packs up to N lanes per vector, and double-buffers completed vectors
// so collection continues while the consumer holds off.
module embedding_packer #(
  parameter int N     = 10,
  parameter int IN_W  = 8,
  parameter int SHIFT = 3,
  parameter int MAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [N*MAG_W-1:0]   out_mag,
  output logic [N-1:0]         out_sign,
  output logic [3:0]           out_len,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {COLLECT, PENDING} state_t;

  localparam logic [3:0]  LAST_LANE = 4'(N - 1);
  localparam logic [IN_W:0] MAG_MAX = (IN_W + 1)'(2 ** MAG_W - 1);

  state_t               state;
  logic [3:0]           count;
  logic [N*MAG_W-1:0]   colMag;
  logic [N-1:0]         colSign;
  logic                 colSat;
  logic [3:0]           colLen;

  logic [N*MAG_W-1:0]   outMag;
  logic [N-1:0]         outSign;
  logic [3:0]           outLen;
  logic                 outSat;
  logic                 outValid;

  // Quantizer: magnitude is formed one bit wider so the most negative input
  // (-2^(IN_W-1)) has a representable absolute value.
  logic [IN_W:0]        extData;
  logic [IN_W:0]        absData;
  logic [IN_W:0]        shifted;
  logic                 qSat;
  logic [MAG_W-1:0]     qMag;

  assign extData = {in_data[IN_W-1], in_data};
  assign absData = in_data[IN_W-1] ? (~extData + (IN_W + 1)'(1)) : extData;
  assign shifted = absData >> SHIFT;
  assign qSat    = shifted > MAG_MAX;
  assign qMag    = qSat ? '1 : shifted[MAG_W-1:0];

  logic accept;
  logic xfer;
  logic slotFree;
  logic done;

  assign in_ready = (state == COLLECT) && !rst;
  assign accept   = in_valid && in_ready;
  assign xfer     = outValid && out_ready;
  assign slotFree = !outValid || out_ready;
  assign done     = accept && ((count == LAST_LANE) || in_last);

  logic [N*MAG_W-1:0]   nextMag;
  logic [N-1:0]         nextSign;
  logic                 nextSat;
  logic [3:0]           nextLen;

  // Merge the incoming element into the lane selected by the counter.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    nextMag  = colMag;
    nextSign = colSign;
    nextSat  = colSat | qSat;
    nextLen  = count + 4'd1;
    for (int i = 0; i < N; i++) begin
      if (count == 4'(i)) begin
        nextMag[i*MAG_W +: MAG_W] = qMag;
        nextSign[i]               = in_data[IN_W-1];
      end
    end
  end

  // Collection / pending control and the registered output slot.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values and evaluation order does not matter.
    if (rst) begin
      state    <= COLLECT;
      count    <= '0;
      colMag   <= '0;
      colSign  <= '0;
      colSat   <= 1'b0;
      colLen   <= '0;
      outMag   <= '0;
      outSign  <= '0;
      outLen   <= '0;
      outSat   <= 1'b0;
      outValid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) outValid <= 1'b0;
          if (accept) begin
            if (done) begin
              count <= '0;
              if (slotFree) begin
                outMag   <= nextMag;
                outSign  <= nextSign;
                outSat   <= nextSat;
                outLen   <= nextLen;
                outValid <= 1'b1;
                colMag   <= '0;
                colSign  <= '0;
                colSat   <= 1'b0;
              end else begin
                colMag   <= nextMag;
                colSign  <= nextSign;
                colSat   <= nextSat;
                colLen   <= nextLen;
                state    <= PENDING;
              end
            end else begin
              colMag  <= nextMag;
              colSign <= nextSign;
              colSat  <= nextSat;
              count   <= nextLen;
            end
          end
        end
        PENDING: begin
          // Hand the parked vector over on the same edge as the transfer,
          // keeping out_valid high with no bubble.
          if (xfer) begin
            outMag  <= colMag;
            outSign <= colSign;
            outSat  <= colSat;
            outLen  <= colLen;
            colMag  <= '0;
            colSign <= '0;
            colSat  <= 1'b0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign out_mag   = outMag;
  assign out_sign  = outSign;
  assign out_len   = outLen;
  assign out_sat   = outSat;
  assign out_valid = outValid;

endmodule
